// File: rtl/cpu_alu_pkg.sv
// rtl/cpu_alu_pkg.sv - op encodings, default datapath width, mul/div sequencer states
package cpu_alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_CMP    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_EOR    = 4'h5;
  localparam logic [3:0] OP_SHL    = 4'h6;
  localparam logic [3:0] OP_SHR    = 4'h7;
  localparam logic [3:0] OP_ROL    = 4'h8;
  localparam logic [3:0] OP_ROR    = 4'h9;
  localparam logic [3:0] OP_PASS_B = 4'hA;
  localparam logic [3:0] OP_INC_B  = 4'hB;
  localparam logic [3:0] OP_DEC_B  = 4'hC;
  localparam logic [3:0] OP_MUL    = 4'hD;
  localparam logic [3:0] OP_DIV    = 4'hE;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_t;

endpackage

// File: rtl/cpu_alu_muldiv.sv
// rtl/cpu_alu_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
//   load      : capture a, b, is_div and begin (only asserted while idle)
//   busy      : WIDTH iteration cycles in progress
//   fin       : one cycle after the last iteration; lo/hi/div_zero are final
//   idle      : ready to accept load
//   lo, hi    : MUL -> product low/high; DIV -> quotient/remainder
//   div_op    : captured operation was DIV
//   div_zero  : captured DIV had a zero divisor
module cpu_alu_muldiv #(
  parameter int WIDTH = cpu_alu_pkg::ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic             idle,
  output logic             div_op,
  output logic             div_zero,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  import cpu_alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  md_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (load) state_nxt = MD_RUN;
      MD_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = MD_FIN;
      MD_FIN:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_RUN);
    fin  = (state == MD_FIN);
    idle = (state == MD_IDLE);
  end

  // Multiply keeps the multiplier in lo and shifts the partial product down
  // through {hi,lo}. Divide shifts the dividend out of lo into hi (remainder)
  // while quotient bits shift into lo from the right.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
    div_shift = {hi, lo[WIDTH-1]};
    // Compare at WIDTH+1 bits: the shifted remainder can exceed WIDTH bits.
    div_ge    = (div_shift >= {1'b0, a_q});
    div_rem   = div_shift[WIDTH-1:0] - a_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      div_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      cnt   <= '0;
      a_q   <= a;
      div_q <= is_div;
      hi    <= '0;
      lo    <= b;
    end else if (state == MD_RUN) begin
      cnt <= cnt + CW'(1);
      if (div_q) begin
        // A zero divisor always "fits": quotient ends all ones, remainder = b.
        if (div_ge) begin
          hi <= div_rem;
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_shift[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign div_op   = div_q;
  assign div_zero = div_q && (a_q == '0);

endmodule

// File: rtl/cpu_alu_iter.sv
// rtl/cpu_alu_iter.sv - ALU with single-cycle ops, BCD add/sub and iterative MUL/DIV
//   start, op, decimal, carry_in, a, b : request and operands (sampled when busy=0)
//   busy                               : MUL/DIV iterating
//   done                               : one-cycle pulse, out/out_hi/flags updated
//   out, out_hi                        : result low/high words (held until next done)
//   neg, ov, zero, carry_out, div_zero : status flags
module cpu_alu_iter #(
  parameter int WIDTH = cpu_alu_pkg::ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             decimal,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             neg,
  output logic             ov,
  output logic             zero,
  output logic             carry_out,
  output logic             div_zero
);
  import cpu_alu_pkg::*;

  localparam int NIB = WIDTH / 4;
  localparam int MSB = WIDTH - 1;

  logic             md_idle, md_fin, md_busy, md_div, md_dz;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic             md_zero, md_neg, md_c;
  logic             is_md, accept;

  logic [WIDTH-1:0] addend;
  logic             cin_eff, is_arith, is_dec;
  logic [WIDTH:0]   bin_sum;
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;
  logic [4:0]       nib;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_ov;

  assign is_md  = (op == OP_MUL) || (op == OP_DIV);
  assign accept = start && md_idle;
  assign busy   = md_busy;

  cpu_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && is_md),
    .is_div   (op == OP_DIV),
    .a        (a),
    .b        (b),
    .busy     (md_busy),
    .fin      (md_fin),
    .idle     (md_idle),
    .div_op   (md_div),
    .div_zero (md_dz),
    .lo       (md_lo),
    .hi       (md_hi)
  );

  // Every adder-based op is b + addend + cin; ov is judged against the
  // effective addend so SUB/CMP/DEC get the right signed-overflow sense.
  always_comb begin
    addend   = '0;
    cin_eff  = 1'b0;
    is_arith = 1'b1;
    case (op)
      OP_ADD:    begin addend = a;  cin_eff = carry_in; end
      OP_SUB:    begin addend = ~a; cin_eff = carry_in; end
      OP_CMP:    begin addend = ~a; cin_eff = 1'b1;     end
      OP_INC_B:  cin_eff = 1'b1;
      OP_DEC_B:  addend = '1;
      OP_PASS_B: ;
      default:   is_arith = 1'b0;
    endcase
    bin_sum = {1'b0, b} + {1'b0, addend} + {{WIDTH{1'b0}}, cin_eff};
  end

  // Nibble-serial decimal adjust. ADD: a digit sum above 9 gets +6 and carries.
  // SUB (b + ~a + cin): a digit without carry-out borrowed, so it gets -6.
  always_comb begin
    bcd_c   = cin_eff;
    bcd_res = '0;
    nib     = '0;
    for (int i = 0; i < NIB; i++) begin
      nib = {1'b0, b[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0000, bcd_c};
      if (op == OP_SUB) begin
        bcd_c = nib[4];
        if (!nib[4]) nib[3:0] = nib[3:0] - 4'd6;
      end else begin
        bcd_c = (nib > 5'd9);
        if (bcd_c) nib = nib + 5'd6;
      end
      bcd_res[4*i +: 4] = nib[3:0];
    end
  end

  always_comb begin
    is_dec = decimal && ((op == OP_ADD) || (op == OP_SUB));
    s_res  = bin_sum[MSB:0];
    s_c    = bin_sum[WIDTH];
    s_ov   = is_arith & (addend[MSB] ^ bin_sum[MSB]) & (b[MSB] ^ bin_sum[MSB]);
    case (op)
      OP_OR:  begin s_res = b | a; s_c = 1'b0; end
      OP_AND: begin s_res = b & a; s_c = 1'b0; end
      OP_EOR: begin s_res = b ^ a; s_c = 1'b0; end
      OP_SHL: begin s_res = {b[MSB-1:0], 1'b0};     s_c = b[MSB]; end
      OP_SHR: begin s_res = {1'b0, b[MSB:1]};       s_c = b[0];   end
      OP_ROL: begin s_res = {b[MSB-1:0], carry_in}; s_c = b[MSB]; end
      OP_ROR: begin s_res = {carry_in, b[MSB:1]};   s_c = b[0];   end
      default: begin
        if (is_dec) begin
          s_res = bcd_res;
          s_c   = bcd_c;
        end else if (!is_arith) begin
          s_res = '0;
          s_c   = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    md_zero = md_div ? (md_lo == '0) : ({md_hi, md_lo} == '0);
    md_neg  = md_div ? md_lo[MSB] : md_hi[MSB];
    md_c    = md_div ? 1'b0 : (md_hi != '0);
  end

  // md_fin and a single-cycle accept are exclusive: accept requires idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      neg       <= 1'b0;
      ov        <= 1'b0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (md_fin) begin
        done      <= 1'b1;
        out       <= md_lo;
        out_hi    <= md_hi;
        neg       <= md_neg;
        ov        <= 1'b0;
        zero      <= md_zero;
        carry_out <= md_c;
        div_zero  <= md_dz;
      end else if (accept && !is_md) begin
        done      <= 1'b1;
        out       <= s_res;
        out_hi    <= '0;
        neg       <= s_res[MSB];
        ov        <= s_ov;
        zero      <= (s_res == '0);
        carry_out <= s_c;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_alu_iter.sv
// tb/tb_cpu_alu_iter.sv - directed-vector bench for cpu_alu_iter (WIDTH=8)
module tb_cpu_alu_iter;
  import cpu_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic       decimal;
  logic       carry_in;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] out, out_hi;
  logic       neg, ov, zero, carry_out, div_zero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       dec;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  wire [20:0] obs = {out, out_hi, neg, ov, zero, carry_out, div_zero};

  always #5 clk = ~clk;

  cpu_alu_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .decimal   (decimal),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .out_hi    (out_hi),
    .neg       (neg),
    .ov        (ov),
    .zero      (zero),
    .carry_out (carry_out),
    .div_zero  (div_zero)
  );

  function automatic logic [20:0] mk(logic [7:0] o, logic [7:0] h,
                                     logic n, logic v, logic z, logic c, logic d);
    return {o, h, n, v, z, c, d};
  endfunction

  function automatic void add_vec(string n, logic [3:0] o, logic d, logic c,
                                  logic [7:0] av, logic [7:0] bv, logic [20:0] e);
    vec_t v;
    v.name = n; v.op = o; v.dec = d; v.cin = c; v.a = av; v.b = bv; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Drive a one-cycle start; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic d, input logic c);
    op = o; a = av; b = bv; decimal = d; carry_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; op = OP_ADD; decimal = 1'b0; carry_in = 1'b1;
    a = 8'h12; b = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 21'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: obs=%h busy=%b done=%b required obs=0 busy=0 done=0", obs, busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    issue(OP_ADD, 8'h50, 8'h50, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || obs !== mk(8'hA0, 8'h00, 1, 1, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL add_50_50: done=%b busy=%b obs=%h required done=1 busy=0 obs=%h",
               done, busy, obs, mk(8'hA0, 8'h00, 1, 1, 0, 0, 0));
    end
    a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || obs !== mk(8'hA0, 8'h00, 1, 1, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL add_hold: done=%b obs=%h required done=0 obs=%h",
               done, obs, mk(8'hA0, 8'h00, 1, 1, 0, 0, 0));
    end
  endtask

  task automatic test_arith;
    tbl.delete();
    add_vec("sub_3_1",    OP_SUB,    0, 1, 8'h01, 8'h03, mk(8'h02, 8'h00, 0, 0, 0, 1, 0));
    add_vec("sub_borrow", OP_SUB,    0, 0, 8'h01, 8'h00, mk(8'hFE, 8'h00, 1, 0, 0, 0, 0));
    add_vec("cmp_eq",     OP_CMP,    0, 0, 8'h42, 8'h42, mk(8'h00, 8'h00, 0, 0, 1, 1, 0));
    add_vec("cmp_ov",     OP_CMP,    0, 0, 8'h01, 8'h80, mk(8'h7F, 8'h00, 0, 1, 0, 1, 0));
    add_vec("inc_ff",     OP_INC_B,  0, 0, 8'h00, 8'hFF, mk(8'h00, 8'h00, 0, 0, 1, 1, 0));
    add_vec("inc_7f",     OP_INC_B,  0, 0, 8'h00, 8'h7F, mk(8'h80, 8'h00, 1, 1, 0, 0, 0));
    add_vec("dec_00",     OP_DEC_B,  0, 0, 8'h00, 8'h00, mk(8'hFF, 8'h00, 1, 0, 0, 0, 0));
    add_vec("dec_80",     OP_DEC_B,  0, 0, 8'h00, 8'h80, mk(8'h7F, 8'h00, 0, 1, 0, 1, 0));
    add_vec("pass_00",    OP_PASS_B, 0, 1, 8'hFF, 8'h00, mk(8'h00, 8'h00, 0, 0, 1, 0, 0));
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dec, tbl[i].cin);
      vectors++;
      if (done !== 1'b1 || obs !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL %s: done=%b obs=%h required done=1 obs=%h", tbl[i].name, done, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_decimal;
    tbl.delete();
    add_vec("bcd_add_58_46", OP_ADD,   1, 1, 8'h58, 8'h46, mk(8'h05, 8'h00, 0, 1, 0, 1, 0));
    add_vec("bcd_add_99_01", OP_ADD,   1, 0, 8'h99, 8'h01, mk(8'h00, 8'h00, 0, 0, 1, 1, 0));
    add_vec("bcd_sub_42_15", OP_SUB,   1, 1, 8'h15, 8'h42, mk(8'h27, 8'h00, 0, 0, 0, 1, 0));
    add_vec("bcd_sub_00_01", OP_SUB,   1, 1, 8'h01, 8'h00, mk(8'h99, 8'h00, 1, 0, 0, 0, 0));
    add_vec("dec_ign_or",    OP_OR,    1, 0, 8'hF0, 8'h0F, mk(8'hFF, 8'h00, 1, 0, 0, 0, 0));
    add_vec("dec_ign_inc",   OP_INC_B, 1, 0, 8'h00, 8'h09, mk(8'h0A, 8'h00, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dec, tbl[i].cin);
      vectors++;
      if (done !== 1'b1 || obs !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL %s: done=%b obs=%h required done=1 obs=%h", tbl[i].name, done, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_logic_shift;
    tbl.delete();
    add_vec("and",     OP_AND, 0, 1, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0, 0));
    add_vec("eor",     OP_EOR, 0, 0, 8'hFF, 8'h0F, mk(8'hF0, 8'h00, 1, 0, 0, 0, 0));
    add_vec("shl_81",  OP_SHL, 0, 1, 8'h00, 8'h81, mk(8'h02, 8'h00, 0, 0, 0, 1, 0));
    add_vec("shr_01",  OP_SHR, 0, 1, 8'h00, 8'h01, mk(8'h00, 8'h00, 0, 0, 1, 1, 0));
    add_vec("rol_40",  OP_ROL, 0, 1, 8'h00, 8'h40, mk(8'h81, 8'h00, 1, 0, 0, 0, 0));
    add_vec("ror_01",  OP_ROR, 0, 1, 8'h00, 8'h01, mk(8'h80, 8'h00, 1, 0, 0, 1, 0));
    add_vec("ror_02",  OP_ROR, 0, 0, 8'h00, 8'h02, mk(8'h01, 8'h00, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dec, tbl[i].cin);
      vectors++;
      if (done !== 1'b1 || obs !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL %s: done=%b obs=%h required done=1 obs=%h", tbl[i].name, done, obs, tbl[i].exp);
      end
    end
  endtask

  task automatic test_mul;
    int e, bc;
    issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_busy_rise: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(e, bc);
    vectors++;
    if (e != 9 || bc != 8) begin
      miscompares++;
      $display("FAIL mul_latency: edges=%0d busy_cycles=%0d required edges=9 busy_cycles=8", e, bc);
    end
    vectors++;
    if (obs !== mk(8'h01, 8'hFE, 1, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL mul_ff_ff: obs=%h required %h", obs, mk(8'h01, 8'hFE, 1, 0, 0, 1, 0));
    end
    issue(OP_MUL, 8'h10, 8'h10, 1'b0, 1'b0);
    wait_done(e, bc);
    vectors++;
    if (e != 9 || obs !== mk(8'h00, 8'h01, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL mul_10_10: edges=%0d obs=%h required edges=9 obs=%h", e, obs, mk(8'h00, 8'h01, 0, 0, 0, 1, 0));
    end
    issue(OP_MUL, 8'h00, 8'h55, 1'b1, 1'b1);
    wait_done(e, bc);
    vectors++;
    if (e != 9 || obs !== mk(8'h00, 8'h00, 0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL mul_zero: edges=%0d obs=%h required edges=9 obs=%h", e, obs, mk(8'h00, 8'h00, 0, 0, 1, 0, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_done_pulse: done=%b busy=%b required done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_div;
    int e, bc;
    issue(OP_DIV, 8'h07, 8'h64, 1'b0, 1'b0);
    wait_done(e, bc);
    vectors++;
    if (e != 9 || bc != 8 || obs !== mk(8'h0E, 8'h02, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL div_64_7: edges=%0d busy=%0d obs=%h required edges=9 busy=8 obs=%h",
               e, bc, obs, mk(8'h0E, 8'h02, 0, 0, 0, 0, 0));
    end
    issue(OP_DIV, 8'h00, 8'h33, 1'b0, 1'b0);
    wait_done(e, bc);
    vectors++;
    if (e != 9 || bc != 8 || obs !== mk(8'hFF, 8'h33, 1, 0, 0, 0, 1)) begin
      miscompares++;
      $display("FAIL div_by_zero: edges=%0d busy=%0d obs=%h required edges=9 busy=8 obs=%h",
               e, bc, obs, mk(8'hFF, 8'h33, 1, 0, 0, 0, 1));
    end
    issue(OP_DIV, 8'hFF, 8'hFE, 1'b0, 1'b0);
    wait_done(e, bc);
    vectors++;
    if (e != 9 || obs !== mk(8'h00, 8'hFE, 0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL div_fe_ff: edges=%0d obs=%h required edges=9 obs=%h", e, obs, mk(8'h00, 8'hFE, 0, 0, 1, 0, 0));
    end
    issue(OP_DIV, 8'h00, 8'h10, 1'b0, 1'b0);
    wait_done(e, bc);
    issue(OP_PASS_B, 8'h00, 8'h12, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b1 || obs !== mk(8'h12, 8'h00, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL single_clears_hi: done=%b obs=%h required done=1 obs=%h",
               done, obs, mk(8'h12, 8'h00, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_ignore_start;
    int e, bc, edges, extra;
    issue(OP_MUL, 8'h0C, 8'h0B, 1'b0, 1'b0);
    edges = 0;
    repeat (3) begin
      @(posedge clk); #1;
      edges++;
    end
    op = OP_ADD; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    edges++;
    start = 1'b0;
    wait_done(e, bc);
    vectors++;
    if (edges + e != 9 || obs !== mk(8'h84, 8'h00, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL mul_ignore_start: edges=%0d obs=%h required edges=9 obs=%h",
               edges + e, obs, mk(8'h84, 8'h00, 0, 0, 0, 0, 0));
    end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL start_not_queued: active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    issue(OP_DIV, 8'h07, 8'h64, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || obs !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_abort_async: busy=%b done=%b obs=%h required busy=0 done=0 obs=0", busy, done, obs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_abort_no_done: active_cycles=%0d required 0", seen);
    end
    issue(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b1 || obs !== mk(8'h03, 8'h00, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL first_start_after_reset: done=%b obs=%h required done=1 obs=%h",
               done, obs, mk(8'h03, 8'h00, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back;
    int e, bc;
    issue(OP_MUL, 8'h03, 8'h05, 1'b0, 1'b0);
    wait_done(e, bc);
    vectors++;
    if (done !== 1'b1 || obs !== mk(8'h0F, 8'h00, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL b2b_mul: done=%b obs=%h required done=1 obs=%h", done, obs, mk(8'h0F, 8'h00, 0, 0, 0, 0, 0));
    end
    op = OP_ADD; a = 8'h10; b = 8'h20; decimal = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || obs !== mk(8'h30, 8'h00, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL b2b_add_in_done: done=%b obs=%h required done=1 obs=%h", done, obs, mk(8'h30, 8'h00, 0, 0, 0, 0, 0));
    end
    op = OP_SUB; carry_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || obs !== mk(8'h10, 8'h00, 0, 0, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL b2b_sub: done=%b obs=%h required done=1 obs=%h", done, obs, mk(8'h10, 8'h00, 0, 0, 0, 1, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_drop: done=%b required 0", done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_decimal();
    test_logic_shift();
    test_mul();
    test_div();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
